pll_freq_mon: RTL

//  Multi-channel reference-clock frequency monitor and lock qualifier; N-channel successor of the housekeeping single-ref check.

---
 rtl/pll_freq_mon_pkg.sv | 28 ++
 rtl/pll_freq_mon_if.sv | 21 ++
 rtl/pll_freq_mon_ch.sv | 116 +++++++++++
 rtl/pll_freq_mon.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/pll_freq_mon_pkg.sv
// Shared types and constants for the reference-clock frequency monitor.
// Holds the channel state encoding, register map offsets, reset thresholds and status bit positions.
package pll_freq_mon_pkg;

  typedef enum logic [1:0] {
    ST_DIS  = 2'd0,
    ST_ACQ  = 2'd1,
    ST_LOCK = 2'd2
  } ch_state_e;

  // address[11:8] selects the page, [7:4] the channel, [3:0] the register
  localparam logic [3:0] PAGE_CH   = 4'h0;
  localparam logic [3:0] PAGE_LOST = 4'h1;
  localparam logic [3:0] PAGE_HIST = 4'h2;

  localparam logic [3:0] OFF_CTRL = 4'h0;
  localparam logic [3:0] OFF_MIN  = 4'h4;
  localparam logic [3:0] OFF_MAX  = 4'h8;
  localparam logic [3:0] OFF_STAT = 4'hC;

  localparam int unsigned DEF_MIN = 102300;
  localparam int unsigned DEF_MAX = 102500;

  localparam int ST_LOCK_BIT  = 31;
  localparam int ST_VAL_BIT   = 30;
  localparam int ST_STATE_LSB = 28;

endpackage

// File: rtl/pll_freq_mon_if.sv
// Register bus between software master and the frequency monitor.
// Single-cycle strobes, acknowledge one cycle later, no wait states.
interface pll_freq_mon_if;
  logic [31:0] sys_addr;
  logic [31:0] sys_wdata;
  logic        sys_wen;
  logic        sys_ren;
  logic [31:0] sys_rdata;
  logic        sys_ack;
  logic        sys_err;

  modport master (
    output sys_addr, sys_wdata, sys_wen, sys_ren,
    input  sys_rdata, sys_ack, sys_err
  );

  modport slave (
    input  sys_addr, sys_wdata, sys_wen, sys_ren,
    output sys_rdata, sys_ack, sys_err
  );
endinterface

// File: rtl/pll_freq_mon_ch.sv
// One monitored reference: prescaler, 3-FF sync, half-period counter, window check, lock FSM.
// val/lock update one clk_i cycle after the deciding half-period edge; lost_set is combinational.
// No backpressure: measurements are continuous and never stall.
module pll_freq_mon_ch
  import pll_freq_mon_pkg::*;
#(
  parameter int PRE_W = 14,
  parameter int CNT_W = 21,
  parameter int LCK_N = 4
) (
  input  logic             clk_i,
  input  logic             pll_ff_rst,
  input  logic             ref_i,
  input  logic             en,
  input  logic [CNT_W-1:0] thr_min,
  input  logic [CNT_W-1:0] thr_max,
  output logic             val,
  output logic             lock,
  output ch_state_e        state,
  output logic [CNT_W-1:0] meas,
  output logic             lost_set,
  output logic             smp_vld,
  output logic [CNT_W-1:0] smp_dat
);

  logic [PRE_W-1:0] pre_q;
  logic [2:0]       sync_q;
  logic [CNT_W-1:0] cnt_q;
  logic [3:0]       good_q, good_d;
  ch_state_e        state_q, state_d;
  logic             hp_edge, timeout, in_win, good_ev, bad_ev;

  always_ff @(posedge ref_i or negedge pll_ff_rst) begin
    if (!pll_ff_rst) pre_q <= '0;
    else             pre_q <= pre_q + 1'b1;
  end

  always_ff @(posedge clk_i or negedge pll_ff_rst) begin
    if (!pll_ff_rst) sync_q <= '0;
    else             sync_q <= {sync_q[1:0], pre_q[PRE_W-1]};
  end

  assign hp_edge = sync_q[2] ^ sync_q[1];
  assign timeout = cnt_q[CNT_W-1];
  assign in_win  = (cnt_q > thr_min) && (cnt_q < thr_max);
  assign good_ev = hp_edge && in_win;
  assign bad_ev  = (hp_edge && !in_win) || (!hp_edge && timeout);

  // counter starts saturated so nothing qualifies before the first real half-period
  always_ff @(posedge clk_i or negedge pll_ff_rst) begin
    if (!pll_ff_rst) begin
      cnt_q <= {1'b1, {(CNT_W-1){1'b0}}};
      meas  <= '0;
      val   <= 1'b0;
    end else if (hp_edge) begin
      meas  <= cnt_q;
      cnt_q <= CNT_W'(1);
      val   <= in_win;
    end else if (timeout) begin
      val   <= 1'b0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  always_comb begin
    state_d  = state_q;
    good_d   = good_q;
    lost_set = 1'b0;
    case (state_q)
      ST_DIS: begin
        good_d = '0;
        if (en) state_d = ST_ACQ;
      end
      ST_ACQ: begin
        if (good_ev) begin
          good_d = good_q + 1'b1;
          if (good_d == 4'(LCK_N)) state_d = ST_LOCK;
        end else if (bad_ev) begin
          good_d = '0;
        end
      end
      ST_LOCK: begin
        if (bad_ev) begin
          state_d  = ST_ACQ;
          good_d   = '0;
          lost_set = 1'b1;
        end
      end
      default: state_d = ST_DIS;
    endcase
    // software disable is not a loss event
    if (!en) begin
      state_d  = ST_DIS;
      good_d   = '0;
      lost_set = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge pll_ff_rst) begin
    if (!pll_ff_rst) begin
      state_q <= ST_DIS;
      good_q  <= '0;
      lock    <= 1'b0;
    end else begin
      state_q <= state_d;
      good_q  <= good_d;
      lock    <= (state_d == ST_LOCK);
    end
  end

  assign state   = state_q;
  assign smp_vld = hp_edge && en;
  assign smp_dat = cnt_q;

endmodule

// File: rtl/pll_freq_mon.sv
// N-channel reference-clock frequency monitor: register file, bus decode, sticky loss flags, IRQ.
// Bus ack and read data one cycle after the strobe; PLL_FREQ_MON_HIST_EN adds min/max history at 0x200.
// No backpressure: every strobe is acknowledged the next cycle, sys_err is always 0.
module pll_freq_mon
  import pll_freq_mon_pkg::*;
#(
  parameter int NCH   = 2,
  parameter int PRE_W = 14,
  parameter int CNT_W = 21,
  parameter int LCK_N = 4
) (
  input  logic           clk_i,
  input  logic           pll_ff_rst,
  input  logic [NCH-1:0] ref_i,
  output logic [NCH-1:0] val_o,
  output logic [NCH-1:0] lock_o,
  output logic           irq_o,
  pll_freq_mon_if.slave  sys
);

  logic [NCH-1:0]            en_q, mask_q, lost_q, lost_clr;
  logic [CNT_W-1:0]          min_q [NCH];
  logic [CNT_W-1:0]          max_q [NCH];
  logic [NCH-1:0][CNT_W-1:0] meas_w, smp_dat_w;
  logic [NCH-1:0]            lost_set_w, smp_vld_w;
  ch_state_e                 st_w [NCH];
  logic [11:0]               a;
  logic [3:0]                page, ch_sel, off;
  logic [31:0]               rd_mux;
  logic                      unused_bus;

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    pll_freq_mon_ch #(.PRE_W(PRE_W), .CNT_W(CNT_W), .LCK_N(LCK_N)) u_ch (
      .clk_i     (clk_i),
      .pll_ff_rst(pll_ff_rst),
      .ref_i     (ref_i[g]),
      .en        (en_q[g]),
      .thr_min   (min_q[g]),
      .thr_max   (max_q[g]),
      .val       (val_o[g]),
      .lock      (lock_o[g]),
      .state     (st_w[g]),
      .meas      (meas_w[g]),
      .lost_set  (lost_set_w[g]),
      .smp_vld   (smp_vld_w[g]),
      .smp_dat   (smp_dat_w[g])
    );
  end

  assign a          = sys.sys_addr[11:0];
  assign page       = a[11:8];
  assign ch_sel     = a[7:4];
  assign off        = a[3:0];
  assign unused_bus = ^{sys.sys_addr[31:12], sys.sys_wdata[31:CNT_W]};
  assign lost_clr   = (sys.sys_wen && page == PAGE_LOST && a[7:0] == 8'h00) ? sys.sys_wdata[NCH-1:0] : '0;
  assign irq_o      = |(lost_q & mask_q);
  assign sys.sys_err = 1'b0;

  always_ff @(posedge clk_i or negedge pll_ff_rst) begin
    if (!pll_ff_rst) begin
      en_q   <= '1;
      mask_q <= '0;
      lost_q <= '0;
      for (int c = 0; c < NCH; c++) begin
        min_q[c] <= CNT_W'(DEF_MIN);
        max_q[c] <= CNT_W'(DEF_MAX);
      end
    end else begin
      // set wins over a same-cycle clear so no loss is ever missed
      lost_q <= (lost_q & ~lost_clr) | lost_set_w;
      for (int c = 0; c < NCH; c++) begin
        if (sys.sys_wen && page == PAGE_CH && ch_sel == 4'(c)) begin
          case (off)
            OFF_CTRL: begin
              en_q[c]   <= sys.sys_wdata[0];
              mask_q[c] <= sys.sys_wdata[1];
            end
            OFF_MIN: min_q[c] <= sys.sys_wdata[CNT_W-1:0];
            OFF_MAX: max_q[c] <= sys.sys_wdata[CNT_W-1:0];
            default: ;
          endcase
        end
      end
    end
  end

`ifdef PLL_FREQ_MON_HIST_EN
  logic [CNT_W-1:0] hmin_q [NCH];
  logic [CNT_W-1:0] hmax_q [NCH];

  always_ff @(posedge clk_i or negedge pll_ff_rst) begin
    if (!pll_ff_rst) begin
      for (int c = 0; c < NCH; c++) begin
        hmin_q[c] <= '1;
        hmax_q[c] <= '0;
      end
    end else begin
      for (int c = 0; c < NCH; c++) begin
        if (sys.sys_wen && page == PAGE_HIST && !a[7] && a[6:3] == 4'(c)) begin
          hmin_q[c] <= '1;
          hmax_q[c] <= '0;
        end else if (smp_vld_w[c]) begin
          if (smp_dat_w[c] < hmin_q[c]) hmin_q[c] <= smp_dat_w[c];
          if (smp_dat_w[c] > hmax_q[c]) hmax_q[c] <= smp_dat_w[c];
        end
      end
    end
  end
`else
  logic unused_hist;
  assign unused_hist = ^{smp_vld_w, smp_dat_w};
`endif

  always_comb begin
    rd_mux = '0;
    case (page)
      PAGE_CH: begin
        for (int c = 0; c < NCH; c++) begin
          if (ch_sel == 4'(c)) begin
            case (off)
              OFF_CTRL: rd_mux = {30'd0, mask_q[c], en_q[c]};
              OFF_MIN:  rd_mux = 32'(min_q[c]);
              OFF_MAX:  rd_mux = 32'(max_q[c]);
              OFF_STAT: begin
                rd_mux = 32'(meas_w[c]);
                rd_mux[ST_LOCK_BIT]         = lock_o[c];
                rd_mux[ST_VAL_BIT]          = val_o[c];
                rd_mux[ST_STATE_LSB +: 2]   = st_w[c];
              end
              default: ;
            endcase
          end
        end
      end
      PAGE_LOST: if (a[7:0] == 8'h00) rd_mux = 32'(lost_q);
`ifdef PLL_FREQ_MON_HIST_EN
      PAGE_HIST: begin
        for (int c = 0; c < NCH; c++) begin
          if (!a[7] && a[6:3] == 4'(c)) rd_mux = a[2] ? 32'(hmax_q[c]) : 32'(hmin_q[c]);
        end
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge pll_ff_rst) begin
    if (!pll_ff_rst) begin
      sys.sys_ack   <= 1'b0;
      sys.sys_rdata <= '0;
    end else begin
      sys.sys_ack <= sys.sys_wen || sys.sys_ren;
      if (sys.sys_ren) sys.sys_rdata <= rd_mux;
    end
  end

endmodule
